// File: rtl/mem_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_controller
// Description : CPU-to-memory bus controller between the MAR/MBR register
//               side and the instruction ROM / data RAM. It turns one-cycle
//               read/write/fetch requests into memory strobes that are held
//               until the memory signals ready. It reports completion with a
//               one-cycle done pulse and an error flag.
//               Optional macro BUS_TIMEOUT_EN: abort an access that has
//               waited TIMEOUT_CYCLES cycles without i_mem_ready.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_rd_req, i_wr_req, i_fetch, i_mar_addr, i_mbr_wdata  - request
//               o_mbr_rdata                                           - read data
//               o_busy, o_done, o_err                                 - status
//               o_instr_rom_read, o_data_ram_read, o_data_ram_write   - strobes
//               o_mem_addr, o_mem_wdata, i_mem_rdata, i_mem_ready     - memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_controller #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_mar_addr,
  input  logic [DATA_W-1:0] i_mbr_wdata,
  output logic [DATA_W-1:0] o_mbr_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_instr_rom_read,
  output logic              o_data_ram_read,
  output logic              o_data_ram_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fetch_q, fetch_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;

  logic w_illegal;
  logic w_access;

  // Both directions at once, or a write aimed at ROM, cannot be serviced.
  assign w_illegal = (i_rd_req & i_wr_req) | (i_wr_req & i_fetch);

`ifdef BUS_TIMEOUT_EN
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  logic w_limit;
  // cnt_q counts the wait cycles already completed, so the current ACCESS
  // cycle is wait number cnt_q+1. Aborting when that reaches TIMEOUT_CYCLES
  // limits the strobe to exactly TIMEOUT_CYCLES cycles.
  assign w_limit = (cnt_q == c_cnt_last);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fetch_d = fetch_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_illegal) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (i_rd_req | i_wr_req) begin
          addr_d  = i_mar_addr;
          wdata_d = i_mbr_wdata;
          fetch_d = i_fetch;
          wr_d    = i_wr_req;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (i_mem_ready) begin
          if (!wr_q) rdata_d = i_mem_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (w_limit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
`endif
        else begin
          if (cnt_q != c_cnt_max) cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fetch_q <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fetch_q <= fetch_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // All memory-side outputs decode from registered state only, so
  // i_mem_ready has no combinational path to any strobe.
  assign w_access         = (state_q == S_ACCESS);
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = (state_q == S_DONE);
  assign o_err            = (state_q == S_DONE) & err_q;
  assign o_mbr_rdata      = rdata_q;
  assign o_instr_rom_read = w_access & fetch_q;
  assign o_data_ram_read  = w_access & ~fetch_q & ~wr_q;
  assign o_data_ram_write = w_access & ~fetch_q & wr_q;
  assign o_mem_addr       = w_access ? addr_q : '0;
  assign o_mem_wdata      = (w_access & wr_q) ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_controller
// Description : Self-checking bench for mem_bus_controller: table of directed
//               transactions plus hand-written reset, timeout and
//               reset-mid-access sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_controller;

  logic        clk;
  logic        rst;
  logic        rd_req, wr_req, fetch;
  logic [7:0]  mar_addr;
  logic [15:0] mbr_wdata;
  logic [15:0] mbr_rdata;
  logic        busy, done, err;
  logic        rom_rd, ram_rd, ram_wr;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_bus_controller #(
    .DATA_W(16), .ADDR_W(8), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req), .i_wr_req(wr_req), .i_fetch(fetch),
    .i_mar_addr(mar_addr), .i_mbr_wdata(mbr_wdata),
    .o_mbr_rdata(mbr_rdata),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_instr_rom_read(rom_rd), .o_data_ram_read(ram_rd), .o_data_ram_write(ram_wr),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, fetch;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int          delay;      // ready-low cycles before ready
    logic        illegal;
    logic [2:0]  strb;       // {rom_rd, ram_rd, ram_wr}
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int n;
    @(negedge clk);
    rd_req = v.rd; wr_req = v.wr; fetch = v.fetch;
    mar_addr = v.addr; mbr_wdata = v.wdata; mem_rdata = v.mrdata; mem_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    if (v.illegal) begin
      chk($sformatf("v%0d_strobes", idx), {29'd0, rom_rd, ram_rd, ram_wr}, 32'd0);
      chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_err", idx), {31'd0, err}, 32'd1);
      chk($sformatf("v%0d_rdata", idx), {16'd0, mbr_rdata}, {16'd0, v.exp_rdata});
    end else begin
      n = 0; k = 0;
      while (busy && !done && k < 40) begin
        chk($sformatf("v%0d_strobe", idx), {29'd0, rom_rd, ram_rd, ram_wr}, {29'd0, v.strb});
        chk($sformatf("v%0d_addr", idx), {24'd0, mem_addr}, {24'd0, v.addr});
        chk($sformatf("v%0d_wdata", idx), {16'd0, mem_wdata}, {16'd0, (v.wr ? v.wdata : 16'd0)});
        mem_ready = (k == v.delay);
        n++; k++;
        @(negedge clk);
      end
      mem_ready = 1'b0;
      chk($sformatf("v%0d_strobe_cycles", idx), n, v.delay + 1);
      chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_err", idx), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d_rdata", idx), {16'd0, mbr_rdata}, {16'd0, v.exp_rdata});
      chk($sformatf("v%0d_strobes_off", idx), {29'd0, rom_rd, ram_rd, ram_wr}, 32'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_idle_done", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    //            rd    wr    fetch addr   wdata     mrdata    dly ill   strb    exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h12, 16'h0000, 16'hBEEF, 0, 1'b0, 3'b100, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h40, 16'h1234, 16'hDEAD, 3, 1'b0, 3'b001, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h7F, 16'h9999, 16'hA5A5, 1, 1'b0, 3'b010, 16'hA5A5};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h22, 16'h4321, 16'h0F0F, 0, 1'b1, 3'b000, 16'hA5A5};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h23, 16'h4321, 16'h0F0F, 0, 1'b1, 3'b000, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'hFF, 16'h0000, 16'h5A3C, 2, 1'b0, 3'b010, 16'h5A3C};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 16'hFFFF, 0, 1'b0, 3'b100, 16'hFFFF};

    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b0; fetch = 1'b0;
    mar_addr = 8'h0; mbr_wdata = 16'h0; mem_rdata = 16'h0; mem_ready = 1'b0;

    // Reset held two cycles with a read request pending.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_outputs", {busy, done, err, rom_rd, ram_rd, ram_wr, mem_addr, mem_wdata, mbr_rdata}, 46'd0);
    end
    rst = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk("rst_release_busy", {31'd0, busy}, 32'd0);
    chk("rst_release_strobes", {29'd0, rom_rd, ram_rd, ram_wr}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // RAM read with memory never ready.
    @(negedge clk);
    rd_req = 1'b1; fetch = 1'b0; mar_addr = 8'h33; mem_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    n = 0;
    while (ram_rd && n < 25) begin
      n++;
      @(negedge clk);
    end
`ifdef BUS_TIMEOUT_EN
    chk("to_strobe_cycles", n, 4);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", {16'd0, mbr_rdata}, 32'd0);
`else
    chk("nto_strobe_cycles", n, 25);
    chk("nto_strobe_high", {31'd0, ram_rd}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("nto_done", {31'd0, done}, 32'd1);
    chk("nto_err", {31'd0, err}, 32'd0);
    chk("nto_rdata", {16'd0, mbr_rdata}, 32'h1111);
`endif
    @(negedge clk);
    chk("to_idle", {31'd0, busy}, 32'd0);

    // Reset during the second ACCESS cycle of a RAM read.
    rd_req = 1'b1; fetch = 1'b0; mar_addr = 8'h55; mem_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    chk("mr_access1", {31'd0, ram_rd}, 32'd1);
    @(negedge clk);
    chk("mr_access2", {31'd0, ram_rd}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_strobe_off", {29'd0, rom_rd, ram_rd, ram_wr}, 32'd0);
    chk("mr_no_done", {31'd0, done}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rdata", {16'd0, mbr_rdata}, 32'd0);
    @(negedge clk);
    chk("mr_still_no_done", {31'd0, done}, 32'd0);
    run_vec('{1'b1, 1'b0, 1'b0, 8'h56, 16'h0000, 16'hC0DE, 1, 1'b0, 3'b010, 16'hC0DE}, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
